fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing the FIFO write port.
REQ-002 Parameter DATA_SIZE, default 8: FIFO word width.
REQ-003 Parameter CNT_SIZE, default 16: width of the completed-packet counter.
REQ-004 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-005 wrst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester word valid.
REQ-007 req_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-008 req_data  input  NUM_REQ*DATA_SIZE  requester i's word on bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 req_ready  output  NUM_REQ  per-requester word accepted this cycle when ANDed with req_valid.
REQ-010 wfull  input  1  FIFO full flag from the write-side full logic, wclk domain.
REQ-011 winc  output  1  FIFO write increment.
REQ-012 wdata  output  DATA_SIZE  FIFO write data.
REQ-013 grant  output  NUM_REQ  one-hot current owner; all zero when no owner.
REQ-014 busy  output  1  high while a packet owns the port.
REQ-015 pkt_count  output  CNT_SIZE  number of completed packets since reset.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (no owner) and LOCK (one requester owns the port).
REQ-017 In IDLE, if any req_valid bit is high, the block SHALL select the first valid requester at or after rr_ptr, scanning upward modulo NUM_REQ, register it as owner, and enter LOCK on the next edge.
REQ-018 In IDLE, req_ready SHALL be all zero, winc 0, grant 0, busy 0.
REQ-019 Arbitration latency SHALL be exactly one cycle: the first word of a granted packet is accepted no earlier than the cycle after the selection edge.
REQ-020 In LOCK, req_ready[owner] SHALL equal ~wfull; all other req_ready bits SHALL be 0.
REQ-021 winc SHALL equal busy & req_valid[owner] & ~wfull, combinationally.
REQ-022 wdata SHALL equal the owner's req_data slice combinationally in LOCK, and 0 in IDLE.
REQ-023 A word SHALL be transferred exactly when winc is 1; no word SHALL be written while wfull is 1.
REQ-024 In LOCK, a transfer with req_last[owner]=1 SHALL return the FSM to IDLE, set rr_ptr to (owner+1) mod NUM_REQ, and increment pkt_count by 1.
REQ-025 pkt_count SHALL wrap from 2^CNT_SIZE-1 to 0 without saturation.
REQ-026 The owner deasserting req_valid mid-packet SHALL NOT release the lock; the block SHALL wait indefinitely for the remaining words.
REQ-027 Requests from non-owners SHALL be ignored in LOCK; no packet interleaving SHALL occur.
REQ-028 A single-word packet (req_last=1 on first word) SHALL be accepted and released in one LOCK cycle when wfull=0.
REQ-029 wfull rising in LOCK SHALL stall the transfer (winc=0, req_ready=0) while holding ownership; transfer SHALL resume in the first cycle wfull is 0.
REQ-030 A req_last transfer SHALL return to IDLE for one cycle before the next grant; there is no back-to-back grant.

Reset
REQ-031 Asserting wrst_n low SHALL immediately force IDLE, owner=0, rr_ptr=0, pkt_count=0, grant=0, busy=0, req_ready=0, winc=0, wdata=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet without writing further words and SHALL NOT count it.
REQ-033 After reset release, the first arbitration SHALL start scanning from requester 0.

Verification
REQ-034 Reset, then req_valid=4'b0110 held -> requester 1 granted first; after its packet ends, requester 2 granted; pkt_count=2.
REQ-035 Requester 0 sends 3-word packet A0,A1,A2 (last on A2) while requester 3 is valid -> FIFO receives A0,A1,A2 contiguously, then requester 3's words.
REQ-036 wfull=1 for 5 cycles mid-packet -> winc=0 and req_ready=0 for those 5 cycles, grant unchanged, no word lost or duplicated.
REQ-037 Owner drops req_valid for 3 cycles mid-packet while others are valid -> busy stays 1, grant unchanged, winc=0 for 3 cycles.
REQ-038 wrst_n pulsed low during a word 2 transfer of a 4-word packet -> winc=0 immediately, pkt_count=0, next grant scans from requester 0.
REQ-039 2^CNT_SIZE single-word packets with CNT_SIZE=4 (16 packets) -> pkt_count returns to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// fifo_wr_arbiter_if: requester handshake plus FIFO write-port bundle shared by the arbiter and its users.
// Revision 1.0
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 16
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wfull;
  logic                         winc;
  logic [DATA_SIZE-1:0]         wdata;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic [CNT_SIZE-1:0]          pkt_count;

  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant, busy, pkt_count
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, grant, busy, pkt_count
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// fifo_wr_arbiter: round-robin, packet-locking arbiter feeding one FIFO write port.
// Revision 1.0
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 16
) (
  input  wire logic         wclk,
  input  wire logic         wrst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_SIZE-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [OWN_W-1:0]     scan_idx;
  logic [OWN_W-1:0]     sel_idx;
  logic                 sel_found;

  logic [NUM_REQ-1:0]   ready_c;
  logic [NUM_REQ-1:0]   grant_c;
  logic                 winc_c;
  logic                 busy_c;
  logic [DATA_SIZE-1:0] wdata_c;

  logic [DATA_SIZE-1:0] slice [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slice[g] = bus.req_data[g*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  // Scan downward so the requester closest to rr_ptr_q is the last (winning) assignment.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = OWN_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    ready_c   = '0;
    grant_c   = '0;
    winc_c    = 1'b0;
    busy_c    = 1'b0;
    wdata_c   = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        busy_c           = 1'b1;
        grant_c[owner_q] = 1'b1;
        ready_c[owner_q] = ~bus.wfull;
        winc_c           = bus.req_valid[owner_q] & ~bus.wfull;
        wdata_c          = slice[owner_q];
        if (winc_c && bus.req_last[owner_q]) begin
          state_d   = IDLE;
          rr_ptr_d  = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.grant     = grant_c;
  assign bus.winc      = winc_c;
  assign bus.busy      = busy_c;
  assign bus.wdata     = wdata_c;
  assign bus.pkt_count = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// tb_fifo_wr_arbiter: directed packet scenarios checked every cycle against a behavioural arbiter model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DS = 8;
  localparam int CS = 4;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DS), .CNT_SIZE(CS)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DS), .CNT_SIZE(CS)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  // Per-requester word sources: {last, data} entries popped on accepted handshakes.
  logic [8:0]    mem [NR][64];
  int            wr_i [NR];
  int            rd_i [NR];
  logic [NR-1:0] avail;
  logic [NR-1:0] hold;
  logic [NR-1:0] acc;
  int            drop_req;
  int            drop_seen;

  assign bus.req_valid = avail & ~hold;

  initial begin
    avail        = '0;
    acc          = '0;
    drop_seen    = 0;
    bus.req_last = '0;
    bus.req_data = '0;
    for (int i = 0; i < NR; i++) rd_i[i] = 0;
    forever begin
      @(negedge wclk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NR; i++) if (wrst_n && acc[i]) rd_i[i]++;
      if (drop_seen != drop_req) begin
        for (int i = 0; i < NR; i++) rd_i[i] = wr_i[i];
        drop_seen = drop_req;
      end
      for (int i = 0; i < NR; i++) begin
        avail[i]               = (rd_i[i] < wr_i[i]);
        bus.req_last[i]        = mem[i][rd_i[i] % 64][8];
        bus.req_data[i*DS +: DS] = mem[i][rd_i[i] % 64][7:0];
      end
    end
  end

  // Behavioural model: current owner (if any), round-robin start point, packet count.
  bit         m_busy;
  logic [1:0] m_own;
  int         m_ptr;
  int         m_cnt;

  function automatic logic [1:0] pick(input logic [NR-1:0] v, input int p);
    logic [1:0] j;
    for (int k = 0; k < NR; k++) begin
      j = 2'((p + k) % NR);
      if (v[j]) return j;
    end
    return 2'd0;
  endfunction

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_busy <= 1'b0;
      m_own  <= 2'd0;
      m_ptr  <= 0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (bus.req_valid != '0) begin
        m_busy <= 1'b1;
        m_own  <= pick(bus.req_valid, m_ptr);
      end
    end else if (bus.req_valid[m_own] && !bus.wfull && bus.req_last[m_own]) begin
      m_busy <= 1'b0;
      m_ptr  <= (int'(m_own) + 1) % NR;
      m_cnt  <= (m_cnt + 1) % (1 << CS);
    end
  end

  int            checks   = 0;
  int            failures = 0;
  logic [7:0]    got [$];
  logic [NR-1:0] gq  [$];
  logic [NR-1:0] prev_g = '0;
  logic          pend_v = 1'b0;
  logic [7:0]    pend_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_cmp();
    logic [NR-1:0] e_grant;
    e_grant = m_busy ? (4'b0001 << m_own) : 4'b0000;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("req_ready", 32'(bus.req_ready), 32'((m_busy && !bus.wfull) ? e_grant : 4'b0000));
    chk("winc", 32'(bus.winc), 32'(m_busy && bus.req_valid[m_own] && !bus.wfull));
    chk("wdata", 32'(bus.wdata), 32'(m_busy ? bus.req_data[int'(m_own)*DS +: DS] : 8'h00));
    chk("pkt_count", 32'(bus.pkt_count), 32'(m_cnt));
    if (bus.grant != '0 && bus.grant != prev_g) gq.push_back(bus.grant);
    prev_g = bus.grant;
    pend_v = bus.winc;
    pend_d = bus.wdata;
  endtask

  task automatic to_neg();
    @(negedge wclk);
    cycle_cmp();
  endtask

  task automatic to_pos();
    @(posedge wclk);
    if (wrst_n && pend_v) got.push_back(pend_d);
    pend_v = 1'b0;
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    mem[r][wr_i[r] % 64] = {last, d};
    wr_i[r]++;
  endtask

  function automatic logic [8:0] got_at(input int i);
    if (i < got.size()) return {1'b0, got[i]};
    return 9'h1FF;
  endfunction

  function automatic logic [NR:0] gq_at(input int i);
    if (i < gq.size()) return {1'b0, gq[i]};
    return '1;
  endfunction

  task automatic do_reset();
    wrst_n    = 1'b0;
    pend_v    = 1'b0;
    hold      = '0;
    bus.wfull = 1'b0;
    drop_req++;
    to_neg();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_winc", 32'(bus.winc), 0);
    chk("rst_pkt_count", 32'(bus.pkt_count), 0);
    to_pos();
    tick();
    wrst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      to_neg();
      done = !bus.busy;
      for (int i = 0; i < NR; i++) if (rd_i[i] != wr_i[i]) done = 1'b0;
      to_pos();
    end
    chk("idle_timeout", 32'(done), 1);
  endtask

  task automatic wait_busy(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      to_neg();
      if (bus.busy) done = 1'b1;
      else to_pos();
    end
    chk("busy_timeout", 32'(done), 1);
  endtask

  initial begin
    int gb;
    int wb;
    bit hit;
    hold      = '0;
    bus.wfull = 1'b0;
    drop_req  = 0;
    for (int i = 0; i < NR; i++) begin
      wr_i[i] = 0;
      for (int j = 0; j < 64; j++) mem[i][j] = '0;
    end

    // Two requesters valid together: lower one at/after pointer 0 wins, then the other.
    do_reset();
    gb = gq.size(); wb = got.size();
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1); push(2, 8'h21, 1'b1);
    wait_idle(40);
    chk("t1_grant0", 32'(gq_at(gb)), 32'h2);
    chk("t1_grant1", 32'(gq_at(gb + 1)), 32'h4);
    chk("t1_w0", 32'(got_at(wb)), 32'h11);
    chk("t1_w1", 32'(got_at(wb + 1)), 32'h12);
    chk("t1_w2", 32'(got_at(wb + 2)), 32'h21);
    chk("t1_pkt_count", 32'(bus.pkt_count), 2);

    // Three-word packet is not interleaved with a competing requester.
    do_reset();
    gb = gq.size(); wb = got.size();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
    wait_idle(40);
    chk("t2_nwords", got.size() - wb, 5);
    chk("t2_w0", 32'(got_at(wb)), 32'hA0);
    chk("t2_w2", 32'(got_at(wb + 2)), 32'hA2);
    chk("t2_w3", 32'(got_at(wb + 3)), 32'hD0);
    chk("t2_w4", 32'(got_at(wb + 4)), 32'hD1);
    chk("t2_grant1", 32'(gq_at(gb + 1)), 32'h8);

    // Five cycles of wfull mid-packet stall the transfer but keep the lock.
    do_reset();
    wb = got.size();
    push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b0); push(2, 8'h32, 1'b0); push(2, 8'h33, 1'b1);
    wait_busy(20);
    to_pos();
    bus.wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      to_neg();
      chk("t3_stall_winc", 32'(bus.winc), 0);
      chk("t3_stall_ready", 32'(bus.req_ready), 0);
      chk("t3_stall_grant", 32'(bus.grant), 32'h4);
      to_pos();
    end
    bus.wfull = 1'b0;
    wait_idle(40);
    chk("t3_nwords", got.size() - wb, 4);
    for (int i = 0; i < 4; i++) chk("t3_word", 32'(got_at(wb + i)), 32'h30 + i);

    // Owner goes quiet for three cycles while another requester waits.
    do_reset();
    wb = got.size();
    push(1, 8'h40, 1'b0); push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b1); push(3, 8'h60, 1'b1);
    wait_busy(20);
    to_pos();
    hold[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      chk("t4_gap_busy", 32'(bus.busy), 1);
      chk("t4_gap_grant", 32'(bus.grant), 32'h2);
      chk("t4_gap_winc", 32'(bus.winc), 0);
      chk("t4_gap_ready3", 32'(bus.req_ready[3]), 0);
      to_pos();
    end
    hold[1] = 1'b0;
    wait_idle(40);
    chk("t4_w2", 32'(got_at(wb + 2)), 32'h42);
    chk("t4_w3", 32'(got_at(wb + 3)), 32'h60);

    // Reset during the third word of a four-word packet; pointer returns to 0.
    do_reset();
    wb = got.size();
    push(2, 8'h6F, 1'b1);
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b0); push(2, 8'h73, 1'b1);
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      to_neg();
      if (bus.winc && bus.wdata == 8'h72) hit = 1'b1;
      else to_pos();
    end
    chk("t5_reached_word2", 32'(hit), 1);
    chk("t5_cnt_before", 32'(bus.pkt_count), 1);
    #1;
    wrst_n = 1'b0;
    pend_v = 1'b0;
    drop_req++;
    #1;
    chk("t5_rst_winc", 32'(bus.winc), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_ready", 32'(bus.req_ready), 0);
    chk("t5_rst_wdata", 32'(bus.wdata), 0);
    chk("t5_rst_cnt", 32'(bus.pkt_count), 0);
    to_pos();
    tick();
    wrst_n = 1'b1;
    chk("t5_nwords", got.size() - wb, 3);
    chk("t5_last_written", 32'(got_at(wb + 2)), 32'h71);
    gb = gq.size(); wb = got.size();
    push(1, 8'h90, 1'b1); push(3, 8'h80, 1'b1);
    wait_idle(40);
    chk("t5_first_grant", 32'(gq_at(gb)), 32'h2);
    chk("t5_after_w0", 32'(got_at(wb)), 32'h90);
    chk("t5_after_cnt", 32'(bus.pkt_count), 2);

    // Sixteen single-word packets wrap the 4-bit counter to zero.
    do_reset();
    wb = got.size();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < NR; r++) push(r, 8'(8'hC0 + k*4 + r), 1'b1);
    wait_idle(200);
    chk("t6_nwords", got.size() - wb, 16);
    chk("t6_w0", 32'(got_at(wb)), 32'hC0);
    chk("t6_w5", 32'(got_at(wb + 5)), 32'hC5);
    chk("t6_w15", 32'(got_at(wb + 15)), 32'hCF);
    chk("t6_pkt_wrap", 32'(bus.pkt_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
